// File: rtl/mxn_rr_arbiter.sv
// Round-robin arbiter: rotating-priority search from a persistent pointer, registered
// one-hot grant held across an ownership window, optional hold-limit preemption.
module mxn_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
  output logic                       gnt_valid,
  output logic                       preempt
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic              TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               preempt_q, preempt_d;

  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] win;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               release_drop, release_to, others;

  // While granted, the current holder is excluded so a release hands over directly.
  assign cand = (state_q == GRANT) ? (req & ~gnt_q) : req;

  always_comb begin
    int idx;
    win_any = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (!win_any && cand[idx]) begin
        win_any = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
    win = win_any ? (ONE << win_idx) : '0;
  end

  assign release_drop = ~|(req & gnt_q);
  assign others       = |(req & ~gnt_q);
  assign release_to   = TIMEOUT_EN && (hold_q == HOLD_MAX) && others;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d   = GRANT;
          gnt_d     = win;
          gnt_idx_d = win_idx;
          hold_d    = '0;
          ptr_d     = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      GRANT: begin
        if ((release_drop || release_to) && others) begin
          gnt_d     = win;
          gnt_idx_d = win_idx;
          hold_d    = '0;
          ptr_d     = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          preempt_d = release_to && !release_drop;
        end else if (release_drop) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          hold_d    = '0;
        end else if (hold_q < HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = |gnt_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_mxn_rr_arbiter.sv
// Scoreboard bench for mxn_rr_arbiter (NUM_REQ=4, MAX_HOLD=4): the driver queues
// hand-computed expectations, a monitor pops and compares after each rising edge.
module tb_mxn_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  mxn_rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] gnt;
    logic       pre;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [1:0] enc(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got gnt/idx/valid/pre=%b_%b_%b_%b want %b_%b_%b_%b", name,
               act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // Apply inputs for one cycle and queue the outputs expected after the next edge.
  task automatic step(input string name, input logic r, input logic [3:0] rq,
                      input logic [3:0] eg, input logic ep);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.name = name;
    e.gnt  = eg;
    e.pre  = ep;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, {gnt, gnt_idx, gnt_valid, preempt},
              {e.gnt, enc(e.gnt), (e.gnt != 4'b0000), e.pre});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run still active at 100000, want finished");
    $fatal(1, "timeout");
  end

  initial begin : driver
    // Reset held with all requests pending, then first grant goes to 0.
    step("rst0", 1'b1, 4'b1111, 4'b0000, 1'b0);
    step("rst1", 1'b1, 4'b1111, 4'b0000, 1'b0);
    step("first_gnt", 1'b0, 4'b1111, 4'b0001, 1'b0);

    // Rotation: each holder drops for one cycle, others stay asserted.
    step("rot1", 1'b0, 4'b1110, 4'b0010, 1'b0);
    step("rot2", 1'b0, 4'b1101, 4'b0100, 1'b0);
    step("rot3", 1'b0, 4'b1011, 4'b1000, 1'b0);
    step("rot0", 1'b0, 4'b0111, 4'b0001, 1'b0);
    step("rot_idle", 1'b0, 4'b0000, 4'b0000, 1'b0);

    // Lone holder is never preempted (ptr=1 -> search finds 2).
    for (int i = 0; i < 20; i++) step("lone", 1'b0, 4'b0100, 4'b0100, 1'b0);
    step("lone_drop", 1'b0, 4'b0000, 4'b0000, 1'b0);

    // Preemption: ptr=3 so search wraps to 0; each holder gets exactly 4 cycles.
    for (int i = 0; i < 4; i++) step("pre_hold0", 1'b0, 4'b0011, 4'b0001, 1'b0);
    step("pre_to1", 1'b0, 4'b0011, 4'b0010, 1'b1);
    for (int i = 0; i < 3; i++) step("pre_hold1", 1'b0, 4'b0011, 4'b0010, 1'b0);
    step("pre_to0", 1'b0, 4'b0011, 4'b0001, 1'b1);
    step("pre_idle", 1'b0, 4'b0000, 4'b0000, 1'b0);

    // Pointer retention through IDLE.
    step("ptr_g1", 1'b0, 4'b0010, 4'b0010, 1'b0);
    step("ptr_idle1", 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("ptr_wrap0", 1'b0, 4'b0011, 4'b0001, 1'b0);
    step("ptr_idle2", 1'b0, 4'b0000, 4'b0000, 1'b0);
    step("ptr_next1", 1'b0, 4'b0011, 4'b0010, 1'b0);
    step("ptr_idle3", 1'b0, 4'b0000, 4'b0000, 1'b0);

    // Reset mid-grant: holder 3 dropped at the reset edge, then ptr=0 and hold_cnt=0.
    step("mid_g3", 1'b0, 4'b1000, 4'b1000, 1'b0);
    step("mid_hold3", 1'b0, 4'b1001, 4'b1000, 1'b0);
    step("mid_rst", 1'b1, 4'b1001, 4'b0000, 1'b0);
    step("post_rst_g0", 1'b0, 4'b1001, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) step("post_rst_hold0", 1'b0, 4'b1001, 4'b0001, 1'b0);
    step("post_rst_to3", 1'b0, 4'b1001, 4'b1000, 1'b1);
    step("end_idle", 1'b0, 4'b0000, 4'b0000, 1'b0);

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
